// File: rtl/uart_rx_deser.sv
// uart_rx_deser: oversampling UART receive deserializer.
// rxd is synchronized, sampled once per bit at the mid-bit oversample tick, and
// assembled LSB first. Received bytes wait in a one-entry holding register that
// is read over a valid/ready handshake. Framing, overrun and parity errors are
// reported as single-clock pulses.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit checked against PARITY_ODD.
// Without the macro there is no PARITY state and rx_parity_err is tied 0.
module uart_rx_deser #(
   parameter int SYNC_STAGES = 2,
   parameter int OVERSAMPLE  = 16,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_ODD  = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [15:0]          baud_div,
   input  logic                 rx_en,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_busy,
   output logic                 rx_frame_err,
   output logic                 rx_overrun,
   output logic                 rx_parity_err
);

   localparam int SAMP_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS);
   localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(OVERSAMPLE/2 - 1);
   localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_BREAK  = 3'd5;

   logic [SYNC_STAGES-1:0] r_sync;
   logic [15:0]            r_tick_cnt;
   logic [15:0]            r_div_lat;
   logic [SAMP_W-1:0]      r_samp_cnt;
   logic [BIT_W-1:0]       r_bit_cnt;
   logic [2:0]             r_state;
   logic [DATA_BITS-1:0]   r_shift;
   logic [DATA_BITS-1:0]   r_data;
   logic                   r_valid;
   logic                   r_frame_err;
   logic                   r_overrun;

   logic w_rxs;
   logic w_tick;
   logic w_mid;

   assign w_rxs  = r_sync[SYNC_STAGES-1];
   assign w_tick = (r_state != S_IDLE) && (r_tick_cnt == r_div_lat);
   // The start bit is sampled half a bit in; every later bit a full bit after the previous one.
   assign w_mid  = w_tick && (r_samp_cnt == ((r_state == S_START) ? SAMP_MID : SAMP_LAST));

   // Synchronize the asynchronous rxd pin; flops reset to the idle-high line level.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state always uses non-blocking (<=) so every flop sees pre-edge values.
      if (rst) r_sync <= '1;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
   end

   // Oversample tick divider; held at 0 while idle, divisor latched at each wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick_cnt <= '0;
         r_div_lat  <= '0;
      end else if (r_state == S_IDLE || w_tick) begin
         r_tick_cnt <= '0;
         r_div_lat  <= baud_div;
      end else begin
         r_tick_cnt <= r_tick_cnt + 16'd1;
      end
   end

   // Ticks within the current bit; restarts at every sample point.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   r_samp_cnt <= '0;
      else if (r_state == S_IDLE) r_samp_cnt <= '0;
      else if (w_mid)            r_samp_cnt <= '0;
      else if (w_tick)           r_samp_cnt <= r_samp_cnt + 1'b1;
   end

`ifdef UART_RX_PARITY_EN
   logic r_par_bad;
   logic r_parity_err;
   assign rx_parity_err = r_parity_err;
`else
   assign rx_parity_err = 1'b0;
`endif

   // Frame state machine, holding register and error pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bad    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         // Consumer takes the byte; a delivery below in the same cycle overrides this.
         if (r_valid && rx_ready) r_valid <= 1'b0;

         if (!rx_en) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (!w_rxs) r_state <= S_START;
               end
               S_START: begin
                  if (w_mid) begin
                     r_bit_cnt <= '0;
                     r_state   <= w_rxs ? S_IDLE : S_DATA;
                  end
               end
               S_DATA: begin
                  if (w_mid) begin
                     r_shift   <= {w_rxs, r_shift[DATA_BITS-1:1]};
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        r_state <= S_PARITY;
`else
                        r_state <= S_STOP;
`endif
                     end
                  end
               end
`ifdef UART_RX_PARITY_EN
               S_PARITY: begin
                  if (w_mid) begin
                     r_par_bad <= ((^r_shift) ^ w_rxs) != PARITY_ODD[0];
                     r_state   <= S_STOP;
                  end
               end
`endif
               S_STOP: begin
                  if (w_mid) begin
                     if (w_rxs) begin
                        r_state <= S_IDLE;
                        if (!r_valid || rx_ready) begin
                           r_data  <= r_shift;
                           r_valid <= 1'b1;
                        end else begin
                           r_overrun <= 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        r_parity_err <= r_par_bad;
`endif
                     end else begin
                        r_frame_err <= 1'b1;
                        r_state     <= S_BREAK;
                     end
                  end
               end
               S_BREAK: begin
                  if (w_rxs) r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign rx_data      = r_data;
   assign rx_valid     = r_valid;
   assign rx_busy      = (r_state != S_IDLE);
   assign rx_frame_err = r_frame_err;
   assign rx_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: self-checking bench for uart_rx_deser (baud_div=3, 64 clk per bit).
// Table-driven frames, hand-written corner sequences and a randomized frame stream
// compared against a queue-based reference model of the serial protocol.
module tb_uart_rx_deser;

   localparam int BIT_CLK = 64;
   localparam bit PAR_ODD = 1'b0;

   logic       clk = 1'b0;
   logic       rst;
   logic [15:0] baud_div;
   logic       rx_en;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       rx_busy;
   logic       rx_frame_err;
   logic       rx_overrun;
   logic       rx_parity_err;

   uart_rx_deser dut (
      .clk          (clk),
      .rst          (rst),
      .baud_div     (baud_div),
      .rx_en        (rx_en),
      .rxd          (rxd),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .rx_busy      (rx_busy),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun),
      .rx_parity_err(rx_parity_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: everything observed on the outputs, sampled on the falling edge.
   logic [7:0] got_q[$];
   int n_valid_cyc = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
   logic busy_at_rise = 1'b0;
   logic prev_valid   = 1'b0;

   always @(negedge clk) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (rx_valid) n_valid_cyc++;
      if (rx_valid && !prev_valid) busy_at_rise = rx_busy;
      n_ferr += int'(rx_frame_err);
      n_ovr  += int'(rx_overrun);
      n_perr += int'(rx_parity_err);
      prev_valid = rx_valid;
   end

   int s_got, s_vc, s_ferr, s_ovr, s_perr;
   task automatic snap();
      s_got  = got_q.size();
      s_vc   = n_valid_cyc;
      s_ferr = n_ferr;
      s_ovr  = n_ovr;
      s_perr = n_perr;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic v);
      @(negedge clk) rxd = v;
      repeat (BIT_CLK - 1) @(negedge clk);
   endtask

   task automatic gap(input int n);
      @(negedge clk) rxd = 1'b1;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^d) ^ PAR_ODD ^ par_flip);
`else
      if (par_flip) $display("note: parity flip ignored without parity feature");
`endif
      drive_bit(stop);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_n;     // bytes expected to be handed over
      logic [7:0] exp_data;
      int         exp_ferr;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] exp_q[$];
      int         exp_ferr;

      rst = 1'b1; rx_en = 1'b1; rxd = 1'b1; rx_ready = 1'b1; baud_div = 16'd3;
      idle(5);
      check("reset_data",  rx_data, 0);
      check("reset_valid", rx_valid, 0);
      check("reset_busy",  rx_busy, 0);
      check("reset_errs",  {rx_frame_err, rx_overrun, rx_parity_err}, 0);
      @(negedge clk) rst = 1'b0;
      idle(10);

      vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
      vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
      vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
      vecs[3] = '{8'h3C, 1'b0, 0, 8'h00, 1};
      vecs[4] = '{8'h81, 1'b1, 1, 8'h81, 0};
      vecs[5] = '{8'h5A, 1'b1, 1, 8'h5A, 0};

      // Table-driven frames, consumer always ready.
      for (int v = 0; v < 6; v++) begin
         snap();
         send_frame(vecs[v].data, vecs[v].stop, 1'b0);
         gap(20);
         check("tbl_count", got_q.size() - s_got, vecs[v].exp_n);
         if (got_q.size() > s_got) check("tbl_data", got_q[s_got], vecs[v].exp_data);
         check("tbl_valid_cycles", n_valid_cyc - s_vc, vecs[v].exp_n);
         check("tbl_ferr", n_ferr - s_ferr, vecs[v].exp_ferr);
         check("tbl_ovr",  n_ovr - s_ovr, 0);
         check("tbl_perr", n_perr - s_perr, 0);
         if (v == 0) check("idle_at_valid_rise", busy_at_rise, 0);
         check("tbl_idle_after", rx_busy, 0);
      end

      // Short low glitch: start bit aborts at its mid-sample, nothing reported.
      snap();
      @(negedge clk) rxd = 1'b0;
      idle(20);
      @(negedge clk) rxd = 1'b1;
      idle(100);
      check("glitch_count", got_q.size() - s_got, 0);
      check("glitch_errs", (n_ferr - s_ferr) + (n_ovr - s_ovr), 0);
      check("glitch_idle", rx_busy, 0);

      // Bad stop bit with line held low: one framing error, stays busy until line rises.
      snap();
      send_frame(8'h3C, 1'b0, 1'b0);
      idle(200);
      check("break_ferr", n_ferr - s_ferr, 1);
      check("break_no_valid", n_valid_cyc - s_vc, 0);
      check("break_busy", rx_busy, 1);
      gap(10);
      check("break_exit", rx_busy, 0);

      // Holding register full: second byte lost with one overrun pulse.
      @(posedge clk); #1 rx_ready = 1'b0;
      snap();
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      gap(20);
      check("ovr_valid", rx_valid, 1);
      check("ovr_data", rx_data, 8'h11);
      check("ovr_pulse", n_ovr - s_ovr, 1);
      check("ovr_none_taken", got_q.size() - s_got, 0);
      @(posedge clk); #1 rx_ready = 1'b1;
      idle(3);
      check("ovr_drain_valid", rx_valid, 0);
      check("ovr_drain_count", got_q.size() - s_got, 1);
      if (got_q.size() > s_got) check("ovr_drain_data", got_q[s_got], 8'h11);

`ifdef UART_RX_PARITY_EN
      // Even parity: 0x03 has two ones, so a parity bit of 1 is a mismatch.
      snap();
      send_frame(8'h03, 1'b1, 1'b1);
      gap(20);
      check("par_bad_pulse", n_perr - s_perr, 1);
      check("par_bad_delivered", got_q.size() - s_got, 1);
      if (got_q.size() > s_got) check("par_bad_data", got_q[s_got], 8'h03);
      snap();
      send_frame(8'h03, 1'b1, 1'b0);
      gap(20);
      check("par_ok_pulse", n_perr - s_perr, 0);
      check("par_ok_delivered", got_q.size() - s_got, 1);
`endif

      // Receiver disabled mid-frame: partial frame dropped silently.
      snap();
      drive_bit(1'b0);
      drive_bit(1'b1);
      check("en_busy_before", rx_busy, 1);
      @(negedge clk) rx_en = 1'b0;
      idle(2);
      check("en_off_idle", rx_busy, 0);
      for (int i = 0; i < 8; i++) drive_bit(1'b0);
      gap(20);
      check("en_off_nothing", (got_q.size() - s_got) + (n_ferr - s_ferr), 0);
      @(negedge clk) rx_en = 1'b1;
      idle(10);

      // Asynchronous reset in the middle of a data bit.
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      idle(20);
      check("rst_busy_before", rx_busy, 1);
      @(negedge clk) rst = 1'b1;
      #1;
      check("rst_async_data", rx_data, 0);
      check("rst_async_busy", rx_busy, 0);
      check("rst_async_valid", rx_valid, 0);
      idle(3);
      @(negedge clk) begin rst = 1'b0; rxd = 1'b1; end
      idle(20);
      snap();
      send_frame(8'hC3, 1'b1, 1'b0);
      gap(20);
      check("post_rst_count", got_q.size() - s_got, 1);
      if (got_q.size() > s_got) check("post_rst_data", got_q[s_got], 8'hC3);

      // Randomized stream against a queue model of the frame rules.
      snap();
      exp_ferr = 0;
      for (int i = 0; i < 14; i++) begin
         logic [7:0] d;
         logic       stop;
         d    = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         send_frame(d, stop, 1'b0);
         if (stop) exp_q.push_back(d);
         else      exp_ferr++;
         if (stop) begin
            if ($urandom_range(0, 1) == 1) gap($urandom_range(1, 30));
         end else begin
            gap($urandom_range(4, 30));
         end
      end
      gap(20);
      check("rand_count", got_q.size() - s_got, exp_q.size());
      check("rand_ferr", n_ferr - s_ferr, exp_ferr);
      check("rand_ovr", n_ovr - s_ovr, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (s_got + i < got_q.size()) check("rand_data", got_q[s_got + i], exp_q[i]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
